// File: rtl/cache_burst_controller_pkg.sv
// Shared definitions for the L1 cache burst controller.
//   cache_state_t  : controller FSM states
//   CACHE_RESP_OK  : write-response code meaning success
//   idx_width()    : width of a word index for a line of N words (minimum 1)
package cache_burst_controller_pkg;

   typedef enum logic [2:0] {
      CACHE_S_IDLE    = 3'd0,
      CACHE_S_RD_ADDR = 3'd1,
      CACHE_S_RD_DATA = 3'd2,
      CACHE_S_WR_REQ  = 3'd3,
      CACHE_S_WR_RESP = 3'd4
   } cache_state_t;

   localparam logic [31:0] CACHE_RESP_OK = 32'd0;

   function automatic int idx_width(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/cache_burst_controller_beat_counter.sv
// Wrapping beat counter used to index refill words within a cache line.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance by one; wraps to 0 after N-1
//   clr        : synchronous clear (wins over inc)
//   cnt        : current count
//   last       : cnt == N-1
// With N == 1 the count is constantly 0 and every beat is the last one.
module cache_burst_controller_beat_counter #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         last
);

   if (N == 1) begin : g_single
      logic unused_single;
      assign unused_single = ^{clk, rst_n, inc, clr};
      assign cnt  = '0;
      assign last = 1'b1;
   end else begin : g_multi
      logic [W-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
         end else if (clr) begin
            cnt_q <= '0;
         end else if (inc) begin
            cnt_q <= last ? '0 : cnt_q + W'(1);
         end
      end

      assign cnt  = cnt_q;
      assign last = (cnt_q == W'(N - 1));
   end

endmodule

// File: rtl/cache_burst_controller.sv
// Controller for a direct-mapped, write-through L1 cache.
// Refills a line with one burst read, issues write-through bus writes with
// independent address/data handshakes, and reports bus errors.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   p_w_en, p_r_en, hit            processor request and tag-compare result
//   readAddr_*/readData_*          bus read channel (burst of LINE_WORDS beats)
//   writeAddr_*/writeData_*        bus write address/data channels
//   writeResp_*                    bus write response channel
//   refill_idx, dataram_sel        datapath control for the data RAM
//   w_tagram, w_validram,
//   w_dataram, validin             single-cycle RAM write strobes
//   p_ready, p_err                 completion pulse and its failure qualifier
// Outputs are combinational from state and inputs, and forced to 0 while
// rst_n is low (readAddr_len is a constant).
module cache_burst_controller
   import cache_burst_controller_pkg::*;
#(
   parameter int LINE_WORDS  = 4,
   parameter int BE_W        = 4,
   parameter bit WRITE_ALLOC = 1'b0
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [BE_W-1:0]                     p_w_en,
   input  logic                                p_r_en,
   input  logic                                hit,
   input  logic                                readAddr_ready,
   input  logic                                readData_valid,
   input  logic                                readData_err,
   input  logic                                writeAddr_ready,
   input  logic                                writeData_ready,
   input  logic                                writeResp_valid,
   input  logic [31:0]                         writeResp_msg,
   output logic                                readAddr_valid,
   output logic [7:0]                          readAddr_len,
   output logic                                readData_ready,
   output logic                                writeAddr_valid,
   output logic                                writeData_valid,
   output logic                                writeResp_ready,
   output logic [idx_width(LINE_WORDS)-1:0]    refill_idx,
   output logic                                dataram_sel,
   output logic                                w_tagram,
   output logic                                w_validram,
   output logic                                w_dataram,
   output logic                                validin,
   output logic                                p_ready,
   output logic                                p_err
);

   localparam int IDX_W = idx_width(LINE_WORDS);

   cache_state_t     state;
   logic             addr_done;
   logic             data_done;
   logic             wr_hit;
   logic             err;
   logic [IDX_W-1:0] cnt;
   logic             cnt_last;

   logic wr_req;
   logic beat;
   logic addr_hs;
   logic data_hs;
   logic addr_ok;
   logic data_ok;
   logic resp_ok;

   assign wr_req  = |p_w_en;
   assign beat    = (state == CACHE_S_RD_DATA) && readData_valid;
   assign addr_hs = (state == CACHE_S_WR_REQ) && !addr_done && writeAddr_ready;
   assign data_hs = (state == CACHE_S_WR_REQ) && !data_done && writeData_ready;
   // A channel counts as done if it finished earlier or handshakes this cycle.
   assign addr_ok = addr_done | addr_hs;
   assign data_ok = data_done | data_hs;
   assign resp_ok = (writeResp_msg == CACHE_RESP_OK);

   assign readAddr_len = 8'(LINE_WORDS - 1);

   cache_burst_controller_beat_counter #(
      .N (LINE_WORDS),
      .W (IDX_W)
   ) u_beat_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (beat),
      .clr   (state != CACHE_S_RD_DATA),
      .cnt   (cnt),
      .last  (cnt_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CACHE_S_IDLE;
         addr_done <= 1'b0;
         data_done <= 1'b0;
         wr_hit    <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            CACHE_S_IDLE: begin
               // Writes take priority over reads.
               if (wr_req) begin
                  wr_hit <= hit;
                  state  <= CACHE_S_WR_REQ;
               end else if (p_r_en && !hit) begin
                  state <= CACHE_S_RD_ADDR;
               end
            end
            CACHE_S_RD_ADDR: begin
               if (readAddr_ready) state <= CACHE_S_RD_DATA;
            end
            CACHE_S_RD_DATA: begin
               // Errors are accumulated but never cut the burst short.
               if (readData_valid) begin
                  if (cnt_last) begin
                     err   <= 1'b0;
                     state <= CACHE_S_IDLE;
                  end else begin
                     err <= err | readData_err;
                  end
               end
            end
            CACHE_S_WR_REQ: begin
               if (addr_ok && data_ok) begin
                  addr_done <= 1'b0;
                  data_done <= 1'b0;
                  state     <= CACHE_S_WR_RESP;
               end else begin
                  addr_done <= addr_ok;
                  data_done <= data_ok;
               end
            end
            CACHE_S_WR_RESP: begin
               if (writeResp_valid) begin
                  // Write-allocate miss: memory already holds the new data,
                  // so the refill brings the updated line into the cache.
                  if (resp_ok && !wr_hit && WRITE_ALLOC) state <= CACHE_S_RD_ADDR;
                  else                                   state <= CACHE_S_IDLE;
               end
            end
            default: state <= CACHE_S_IDLE;
         endcase
      end
   end

   always_comb begin
      readAddr_valid  = 1'b0;
      readData_ready  = 1'b0;
      writeAddr_valid = 1'b0;
      writeData_valid = 1'b0;
      writeResp_ready = 1'b0;
      refill_idx      = '0;
      dataram_sel     = 1'b0;
      w_tagram        = 1'b0;
      w_validram      = 1'b0;
      w_dataram       = 1'b0;
      validin         = 1'b0;
      p_ready         = 1'b0;
      p_err           = 1'b0;
      if (rst_n) begin
         case (state)
            CACHE_S_IDLE: begin
               p_ready = !wr_req && p_r_en && hit;
            end
            CACHE_S_RD_ADDR: begin
               readAddr_valid = 1'b1;
            end
            CACHE_S_RD_DATA: begin
               readData_ready = 1'b1;
               refill_idx     = cnt;
               w_dataram      = readData_valid;
               if (readData_valid && cnt_last) begin
                  w_tagram   = 1'b1;
                  w_validram = 1'b1;
                  validin    = !(err | readData_err);
                  p_ready    = 1'b1;
                  p_err      = err | readData_err;
               end
            end
            CACHE_S_WR_REQ: begin
               writeAddr_valid = !addr_done;
               writeData_valid = !data_done;
            end
            CACHE_S_WR_RESP: begin
               writeResp_ready = 1'b1;
               if (writeResp_valid) begin
                  if (!resp_ok) begin
                     p_ready = 1'b1;
                     p_err   = 1'b1;
                  end else if (wr_hit) begin
                     w_dataram   = 1'b1;
                     dataram_sel = 1'b1;
                     p_ready     = 1'b1;
                  end else if (!WRITE_ALLOC) begin
                     p_ready = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
